// File: rtl/mem_mp.sv
// Multi-port word memory with round-robin arbitration.
// One access per cycle is granted among the requesting ports. Writes use
// per-byte strobes; reads travel through an RD_LAT-deep pipeline tagged with
// the requesting port. Out-of-range accesses are accepted but only raise err.
module mem_mp #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NPORTS     = 2,
    parameter int RD_LAT     = 1
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic [NPORTS-1:0]              valid,
    input  logic [NPORTS-1:0]              wr_rd,
    input  logic [NPORTS*ADDR_WIDTH-1:0]   addr,
    input  logic [NPORTS*WIDTH-1:0]        wdata,
    input  logic [NPORTS*(WIDTH/8)-1:0]    wstrb,
    output logic [NPORTS-1:0]              ready,
    output logic [NPORTS-1:0]              rvalid,
    output logic [NPORTS*WIDTH-1:0]        rdata,
    output logic [NPORTS-1:0]              err
);

    localparam int NB = WIDTH / 8;
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int L  = RD_LAT - 1;

    logic [PW-1:0]         ptr;
    logic [NPORTS-1:0]     gnt;
    logic [PW-1:0]         gidx;
    logic                  acc;
    logic [ADDR_WIDTH-1:0] ga;
    logic                  gwr;
    logic [WIDTH-1:0]      gwd;
    logic [NB-1:0]         gst;
    logic                  in_range;

    logic [WIDTH-1:0]      mem [DEPTH];

    // Read pipeline: valid, port tag, out-of-range flag and sampled word.
    logic                  pv    [RD_LAT];
    logic [PW-1:0]         pport [RD_LAT];
    logic                  poor  [RD_LAT];
    logic [WIDTH-1:0]      pdata [RD_LAT];

    // Last word presented to each port, so rdata holds between strobes.
    logic [WIDTH-1:0]      hold  [NPORTS];

    // Round-robin pick: scan from the pointer, first requesting port wins.
    always_comb begin
        int      p;
        logic [PW-1:0] pi;
        gnt  = '0;
        gidx = '0;
        acc  = 1'b0;
        p    = 0;
        pi   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            p  = (int'(ptr) + i) % NPORTS;
            pi = PW'(p);
            if (!acc && valid[pi]) begin
                acc      = 1'b1;
                gnt[pi]  = 1'b1;
                gidx     = pi;
            end
        end
    end

    // Mux out the granted port's request fields.
    always_comb begin
        ga       = addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
        gwr      = wr_rd[gidx];
        gwd      = wdata[gidx*WIDTH +: WIDTH];
        gst      = wstrb[gidx*NB +: NB];
        in_range = 32'(ga) < 32'(DEPTH);
    end

    assign ready = res ? '0 : gnt;

    // Pointer moves past the accepted port; holds when nothing is accepted.
    always_ff @(posedge clk or posedge res) begin
        if (res)
            ptr <= '0;
        else if (acc)
            ptr <= (int'(gidx) == NPORTS - 1) ? '0 : gidx + 1'b1;
    end

    // Byte-lane writes for in-range accepted writes; whole array clears on reset.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int d = 0; d < DEPTH; d++)
                mem[d] <= '0;
        end else if (acc && gwr && in_range) begin
            for (int b = 0; b < NB; b++)
                if (gst[b])
                    mem[ga][b*8 +: 8] <= gwd[b*8 +: 8];
        end
    end

    // Read pipeline: reads and any out-of-range access enter stage 0.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pv[s]    <= 1'b0;
                pport[s] <= '0;
                poor[s]  <= 1'b0;
                pdata[s] <= '0;
            end
        end else begin
            pv[0]    <= acc && (!gwr || !in_range);
            pport[0] <= gidx;
            poor[0]  <= !in_range;
            pdata[0] <= (acc && !gwr && in_range) ? mem[ga] : '0;
            for (int s = 1; s < RD_LAT; s++) begin
                pv[s]    <= pv[s-1];
                pport[s] <= pport[s-1];
                poor[s]  <= poor[s-1];
                pdata[s] <= pdata[s-1];
            end
        end
    end

    // Capture the presented word per port; out-of-range responses show zero.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int p = 0; p < NPORTS; p++)
                hold[p] <= '0;
        end else if (pv[L]) begin
            hold[pport[L]] <= poor[L] ? '0 : pdata[L];
        end
    end

    // Decode the final pipeline stage onto the per-port response outputs.
    always_comb begin
        rvalid = '0;
        err    = '0;
        rdata  = '0;
        for (int p = 0; p < NPORTS; p++)
            rdata[p*WIDTH +: WIDTH] = hold[p];
        if (pv[L]) begin
            if (poor[L]) begin
                err[pport[L]]                   = 1'b1;
                rdata[pport[L]*WIDTH +: WIDTH]  = '0;
            end else begin
                rvalid[pport[L]]                = 1'b1;
                rdata[pport[L]*WIDTH +: WIDTH]  = pdata[L];
            end
        end
    end

endmodule

// File: doc/mem_mp.md
MEM_MP -- requirements
Module: mem_mp

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal values are multiples of 8.
REQ-002 Parameter DEPTH, default 16: number of words; need not be a power of two.
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH): address width in bits.
REQ-004 Parameter NPORTS, default 2: requestor port count, legal range 1..4.
REQ-005 Parameter RD_LAT, default 1: read latency in cycles from acceptance to rvalid, legal range 1..3.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port res, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port valid, input, NPORTS bits: request valid, one bit per port.
REQ-009 Port wr_rd, input, NPORTS bits: 1 = write, 0 = read, per port.
REQ-010 Port addr, input, NPORTS*ADDR_WIDTH bits: word address, port p at slice [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 Port wdata, input, NPORTS*WIDTH bits: write data, port p at slice [p*WIDTH +: WIDTH].
REQ-012 Port wstrb, input, NPORTS*(WIDTH/8) bits: byte write enables, per port.
REQ-013 Port ready, output, NPORTS bits: request accepted this cycle when valid[p] and ready[p] are both high.
REQ-014 Port rvalid, output, NPORTS bits: one-cycle read-response strobe, per port.
REQ-015 Port rdata, output, NPORTS*WIDTH bits: read data, valid only while rvalid[p] is high.
REQ-016 Port err, output, NPORTS bits: one-cycle strobe flagging a rejected out-of-range access.

Function
REQ-017 Storage is a single array of DEPTH words of WIDTH bits, single access per cycle.
REQ-018 Arbitration is round-robin among ports with valid high.
REQ-019 At most one ready bit is high per cycle; ready is combinational from valid and the round-robin pointer.
REQ-020 After reset the pointer favours port 0.
REQ-021 After each acceptance by port p, the pointer moves so that port p+1 (mod NPORTS) has highest priority.
REQ-022 With no acceptance in a cycle, the pointer holds.
REQ-023 A port with valid high and no grant keeps its request pending; no starvation beyond NPORTS-1 cycles.
REQ-024 Write acceptance: each byte lane b with wstrb[b]=1 is updated at the accepting edge; other lanes hold.
REQ-025 A write produces no rvalid.
REQ-026 A write with wstrb all zero completes with no data change.
REQ-027 Read acceptance: the word is sampled at the accepting edge and presented on the accepted port's rdata/rvalid exactly RD_LAT cycles after that edge.
REQ-028 The read path is a RD_LAT-stage pipeline, so back-to-back reads sustain one read per cycle.
REQ-029 The pipeline tags each read with its port index so responses return in order.
REQ-030 Read of an address written in the same accepting cycle is impossible (single grant).
REQ-031 Read in the cycle after a write to the same address returns the new data.
REQ-032 An access with addr >= DEPTH is still accepted (ready high) but performs no write or read.
REQ-033 For that out-of-range access, err[p] pulses high for one cycle, RD_LAT cycles after acceptance.
REQ-034 For that out-of-range access, rvalid[p] stays low and rdata[p] is zero.
REQ-035 rdata of a port holds its last value while rvalid is low.
REQ-036 valid deasserted mid-pending (before grant) withdraws the request with no side effects.

Reset
REQ-037 While res is high, asynchronously and regardless of clk: ready=0.
REQ-038 While res is high, asynchronously and regardless of clk: rvalid=0, err=0, rdata=0.
REQ-039 While res is high, asynchronously and regardless of clk: the pointer = port 0, read pipeline cleared, all memory words = 0.
REQ-040 Reads in flight when res asserts are discarded and never return.
REQ-041 The first acceptance is possible in the first rising edge with res low.

Verification
REQ-042 Reset, then read addr 5 from port 0 with RD_LAT=1 -> ready[0]=1; next cycle rvalid[0]=1 and rdata=0x00.
REQ-043 Port 1 writes 0xA5 to addr 3 with wstrb=1; port 0 then reads addr 3 with RD_LAT=2 -> rdata[0]=0xA5 two cycles after acceptance.
REQ-044 Port 0 and port 1 hold valid high continuously (NPORTS=2) -> grants alternate 0,1,0,1 starting with port 0 after reset.
REQ-045 WIDTH=32: write 0x11223344, then write 0xFFFFFFFF with wstrb=0b0101, then read -> 0x11FF33FF.
REQ-046 DEPTH=10: read addr 12 -> ready=1, err pulses RD_LAT cycles later, rvalid stays 0, memory unchanged.
REQ-047 Assert res one cycle after a read is accepted with RD_LAT=3 -> no rvalid ever appears; all outputs are 0 immediately, without waiting for a clk edge.
